// File: rtl/ex_commit_ctrl.sv
// rtl/ex_commit_ctrl.sv - WB-stage commit/exception/ERTN controller with fetch redirect handshake
// Picks the highest-priority cause, pulses the CSR file, and holds a redirect until fetch accepts it.
module ex_commit_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [4:0]  ws_ex,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  input  logic        redirect_ready,
  output logic        ws_ready,
  output logic        ws_commit,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        flush_pipe,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [15:0] ex_count
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t      state, next_state;
  logic [31:0] redirect_pc_q;
  logic [15:0] ex_count_q;
  logic        event_hit;
  logic        cause_ertn;
  logic [5:0]  cause_ecode;

  // Fixed priority: INT, ADEF, INE, SYS, BRK, ALE, then ERTN as the fallback.
  always_comb begin
    cause_ecode = 6'h00;
    cause_ertn  = 1'b0;
    if (has_int)       cause_ecode = 6'h00;
    else if (ws_ex[0]) cause_ecode = 6'h08;
    else if (ws_ex[1]) cause_ecode = 6'h0D;
    else if (ws_ex[2]) cause_ecode = 6'h0B;
    else if (ws_ex[3]) cause_ecode = 6'h0C;
    else if (ws_ex[4]) cause_ecode = 6'h09;
    else               cause_ertn  = 1'b1;
  end

  assign event_hit = !reset && (state == IDLE) && ws_valid &&
                     (has_int || (ws_ex != 5'd0) || ws_ertn);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (event_hit) next_state = REDIR;
      REDIR:   if (redirect_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ws_ready       = (state == IDLE);
    ws_commit      = 1'b0;
    wb_ex          = 1'b0;
    wb_ecode       = 6'h00;
    wb_esubcode    = 9'h000;
    wb_pc          = 32'h0;
    wb_vaddr       = 32'h0;
    ertn_flush     = 1'b0;
    flush_pipe     = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        ws_commit = !reset && ws_valid && !event_hit;
        if (event_hit) begin
          flush_pipe = 1'b1;
          if (cause_ertn) begin
            ertn_flush = 1'b1;
          end else begin
            wb_ex    = 1'b1;
            wb_ecode = cause_ecode;
            wb_pc    = ws_pc;
            wb_vaddr = ws_vaddr;
          end
        end
      end
      REDIR: begin
        redirect_valid = !reset;
        flush_pipe     = !reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pc_q <= 32'h0;
      ex_count_q    <= 16'h0;
    end else if (event_hit) begin
      redirect_pc_q <= cause_ertn ? ertn_pc : ex_entry;
      if (!cause_ertn && (ex_count_q != 16'hFFFF))
        ex_count_q <= ex_count_q + 16'd1;
    end
  end

  assign redirect_pc = redirect_pc_q;
  assign ex_count    = ex_count_q;

endmodule

// File: tb/tb_ex_commit_ctrl.sv
// tb/tb_ex_commit_ctrl.sv - directed and randomized checks of ex_commit_ctrl against a cause-table model
module tb_ex_commit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [4:0]  ws_ex;
  logic [31:0] ws_vaddr;
  logic        ws_ertn;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        redirect_ready;
  logic        ws_ready, ws_commit, wb_ex, ertn_flush, flush_pipe, redirect_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, redirect_pc;
  logic [15:0] ex_count;

  int vectors = 0;
  int miscompares = 0;

  // Model state: whether a redirect is outstanding, its target, taken-exception count
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_cnt;
  // Expected outputs for the current cycle
  bit          e_ev, e_ertn, e_wb_ex, e_ertn_flush, e_commit, e_flush, e_rv, e_ready;
  logic [5:0]  e_ecode;
  logic [31:0] e_wb_pc, e_wb_vaddr;
  logic [7:0]  codes [5] = '{8'h08, 8'h0D, 8'h0B, 8'h0C, 8'h09};

  ex_commit_ctrl dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_ex(ws_ex),
    .ws_vaddr(ws_vaddr), .ws_ertn(ws_ertn), .has_int(has_int), .ex_entry(ex_entry),
    .ertn_pc(ertn_pc), .redirect_ready(redirect_ready), .ws_ready(ws_ready),
    .ws_commit(ws_commit), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .flush_pipe(flush_pipe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ex_count(ex_count)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    bit found;
    e_ev = !reset && !m_redir && ws_valid && (has_int || ws_ex != 0 || ws_ertn);
    e_ecode = 6'h00;
    found = has_int;
    for (int i = 0; i < 5; i++)
      if (!found && ws_ex[i]) begin
        e_ecode = codes[i][5:0];
        found = 1;
      end
    e_ertn       = !found;
    e_wb_ex      = e_ev && !e_ertn;
    e_ertn_flush = e_ev && e_ertn;
    if (!e_wb_ex) e_ecode = 6'h00;
    e_wb_pc      = e_wb_ex ? ws_pc : 32'h0;
    e_wb_vaddr   = e_wb_ex ? ws_vaddr : 32'h0;
    e_commit     = !reset && !m_redir && ws_valid && !e_ev;
    e_flush      = e_ev || (!reset && m_redir);
    e_rv         = !reset && m_redir;
    e_ready      = !m_redir;
  endfunction

  task automatic clk_step();
    model_eval();
    @(posedge clk);
    if (reset) begin
      m_redir = 0; m_rpc = 32'h0; m_cnt = 0;
    end else if (e_ev) begin
      m_redir = 1;
      m_rpc = e_ertn ? ertn_pc : ex_entry;
      if (!e_ertn && m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (m_redir && redirect_ready) begin
      m_redir = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ws_valid = 0; ws_pc = 32'h0; ws_ex = 5'd0; ws_vaddr = 32'h0; ws_ertn = 0;
    has_int = 0; ex_entry = 32'h0; ertn_pc = 32'h0; redirect_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    ws_valid = 1; has_int = 1; ws_ex = 5'b00100;
    #1;
    vectors++;
    if ({wb_ex, ertn_flush, ws_commit, flush_pipe, redirect_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=00000", {wb_ex, ertn_flush, ws_commit, flush_pipe, redirect_valid});
    end
    clk_step(); clk_step();
    idle_inputs();
    reset = 0;
    #1;
    vectors++;
    if (ex_count !== 16'h0 || redirect_pc !== 32'h0 || ws_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state cnt=%h rpc=%h ready=%b rv=%b exp 0000/0/1/0", ex_count, redirect_pc, ws_ready, redirect_valid);
    end
  endtask

  task automatic test_commit();
    ws_valid = 1; ws_pc = 32'h1C000040;
    #1;
    vectors++;
    if (ws_commit !== 1 || wb_ex !== 0 || flush_pipe !== 0 || wb_ecode !== 0 || wb_pc !== 0) begin
      miscompares++;
      $display("FAIL normal_commit commit=%b wb_ex=%b flush=%b ecode=%h pc=%h exp 1/0/0/0/0", ws_commit, wb_ex, flush_pipe, wb_ecode, wb_pc);
    end
    clk_step();
    #1;
    vectors++;
    if (ws_ready !== 1 || redirect_valid !== 0 || ws_commit !== 1) begin
      miscompares++;
      $display("FAIL stay_idle ready=%b rv=%b commit=%b exp 1/0/1", ws_ready, redirect_valid, ws_commit);
    end
    clk_step();
    idle_inputs();
  endtask

  task automatic test_sys_redirect();
    ws_valid = 1; ws_ex = 5'b00100; ws_pc = 32'h1C000100; ex_entry = 32'h1C008000;
    #1;
    vectors++;
    if (wb_ex !== 1 || wb_ecode !== 6'h0B || wb_pc !== 32'h1C000100 || ws_commit !== 0 || flush_pipe !== 1) begin
      miscompares++;
      $display("FAIL sys_event wb_ex=%b ecode=%h pc=%h commit=%b flush=%b exp 1/0b/1c000100/0/1", wb_ex, wb_ecode, wb_pc, ws_commit, flush_pipe);
    end
    clk_step();
    ex_entry = 32'hDEAD0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (redirect_valid !== 1 || redirect_pc !== 32'h1C008000 || wb_ex !== 0 || ws_commit !== 0 || ws_ready !== 0 || flush_pipe !== 1) begin
        miscompares++;
        $display("FAIL redir_hold%0d rv=%b rpc=%h wb_ex=%b commit=%b ready=%b flush=%b exp 1/1c008000/0/0/0/1", i, redirect_valid, redirect_pc, wb_ex, ws_commit, ws_ready, flush_pipe);
      end
      clk_step();
    end
    redirect_ready = 1;
    #1;
    vectors++;
    if (redirect_valid !== 1) begin
      miscompares++;
      $display("FAIL redir_handshake rv=%b exp 1", redirect_valid);
    end
    clk_step();
    ws_valid = 0; redirect_ready = 0;
    #1;
    vectors++;
    if (redirect_valid !== 0 || ws_ready !== 1 || ex_count !== 16'd1) begin
      miscompares++;
      $display("FAIL redir_done rv=%b ready=%b cnt=%0d exp 0/1/1", redirect_valid, ws_ready, ex_count);
    end
    idle_inputs();
  endtask

  task automatic take_event(input logic [4:0] ex, input bit irq, input bit ertn,
                            input logic [31:0] vaddr, output logic [5:0] code,
                            output logic [8:0] sub, output logic [31:0] va,
                            output bit wx, output bit ef, output bit cm);
    ws_valid = 1; ws_ex = ex; has_int = irq; ws_ertn = ertn; ws_vaddr = vaddr;
    ws_pc = 32'h1C000300; ex_entry = 32'h1C008000; ertn_pc = 32'h1C000204;
    #1;
    code = wb_ecode; sub = wb_esubcode; va = wb_vaddr; wx = wb_ex; ef = ertn_flush; cm = ws_commit;
    clk_step();
    redirect_ready = 1;
    clk_step();
    idle_inputs();
  endtask

  task automatic test_priority();
    logic [5:0] c; logic [8:0] s; logic [31:0] v; bit wx, ef, cm;
    take_event(5'b10001, 1, 0, 32'h3, c, s, v, wx, ef, cm);
    vectors++;
    if (c !== 6'h00 || wx !== 1 || cm !== 0) begin
      miscompares++;
      $display("FAIL int_priority ecode=%h wb_ex=%b commit=%b exp 00/1/0", c, wx, cm);
    end
    take_event(5'b10000, 0, 0, 32'h3, c, s, v, wx, ef, cm);
    vectors++;
    if (c !== 6'h09 || s !== 9'h0 || v !== 32'h3 || wx !== 1) begin
      miscompares++;
      $display("FAIL ale ecode=%h esub=%h vaddr=%h wb_ex=%b exp 09/0/3/1", c, s, v, wx);
    end
    take_event(5'b00001, 0, 0, 32'h0, c, s, v, wx, ef, cm);
    vectors++;
    if (c !== 6'h08 || s !== 9'h0 || wx !== 1) begin
      miscompares++;
      $display("FAIL adef ecode=%h esub=%h wb_ex=%b exp 08/0/1", c, s, wx);
    end
    take_event(5'b01000, 0, 0, 32'h0, c, s, v, wx, ef, cm);
    vectors++;
    if (c !== 6'h0C || wx !== 1) begin
      miscompares++;
      $display("FAIL brk ecode=%h wb_ex=%b exp 0c/1", c, wx);
    end
  endtask

  task automatic test_ertn();
    logic [15:0] cnt0;
    logic [5:0] c; logic [8:0] s; logic [31:0] v; bit wx, ef, cm;
    cnt0 = ex_count;
    ws_valid = 1; ws_ertn = 1; ertn_pc = 32'h1C000204; ex_entry = 32'h1C008000;
    #1;
    vectors++;
    if (ertn_flush !== 1 || wb_ex !== 0 || ws_commit !== 0 || flush_pipe !== 1) begin
      miscompares++;
      $display("FAIL ertn_event flush=%b wb_ex=%b commit=%b fp=%b exp 1/0/0/1", ertn_flush, wb_ex, ws_commit, flush_pipe);
    end
    clk_step();
    #1;
    vectors++;
    if (redirect_pc !== 32'h1C000204 || ex_count !== cnt0 || ertn_flush !== 0) begin
      miscompares++;
      $display("FAIL ertn_redir rpc=%h cnt=%h flush=%b exp 1c000204/%h/0", redirect_pc, ex_count, ertn_flush, cnt0);
    end
    redirect_ready = 1;
    clk_step();
    idle_inputs();
    take_event(5'b00010, 0, 1, 32'h0, c, s, v, wx, ef, cm);
    vectors++;
    if (c !== 6'h0D || wx !== 1 || ef !== 0) begin
      miscompares++;
      $display("FAIL ine_over_ertn ecode=%h wb_ex=%b ertn_flush=%b exp 0d/1/0", c, wx, ef);
    end
  endtask

  task automatic test_saturate_and_reset();
    dut.ex_count_q = 16'hFFFF;
    m_cnt = 65535;
    ws_valid = 1; ws_ex = 5'b01000; ex_entry = 32'h1C008000;
    clk_step();
    #1;
    vectors++;
    if (ex_count !== 16'hFFFF || redirect_valid !== 1) begin
      miscompares++;
      $display("FAIL saturate cnt=%h rv=%b exp ffff/1", ex_count, redirect_valid);
    end
    reset = 1;
    #1;
    vectors++;
    if (redirect_valid !== 0 || flush_pipe !== 0) begin
      miscompares++;
      $display("FAIL reset_in_redir rv=%b flush=%b exp 0/0", redirect_valid, flush_pipe);
    end
    clk_step();
    reset = 0;
    idle_inputs();
    #1;
    vectors++;
    if (redirect_valid !== 0 || ex_count !== 16'h0 || ws_ready !== 1 || redirect_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL after_reset rv=%b cnt=%h ready=%b rpc=%h exp 0/0/1/0", redirect_valid, ex_count, ws_ready, redirect_pc);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset          = ($urandom_range(0, 39) == 0);
      ws_valid       = ($urandom_range(0, 3) != 0);
      ws_pc          = $urandom;
      ws_vaddr       = $urandom;
      ws_ex          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      ws_ertn        = ($urandom_range(0, 5) == 0);
      has_int        = ($urandom_range(0, 7) == 0);
      ex_entry       = $urandom;
      ertn_pc        = $urandom;
      redirect_ready = $urandom_range(0, 1) == 1;
      #1;
      model_eval();
      vectors++;
      if ({ws_ready, ws_commit, wb_ex, ertn_flush, flush_pipe, redirect_valid} !==
          {e_ready, e_commit, e_wb_ex, e_ertn_flush, e_flush, e_rv}) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc,
                 {ws_ready, ws_commit, wb_ex, ertn_flush, flush_pipe, redirect_valid},
                 {e_ready, e_commit, e_wb_ex, e_ertn_flush, e_flush, e_rv});
      end
      vectors++;
      if (wb_ecode !== e_ecode || wb_esubcode !== 9'h0 || wb_pc !== e_wb_pc || wb_vaddr !== e_wb_vaddr) begin
        miscompares++;
        $display("FAIL rand_cause cyc=%0d got=%h/%h/%h/%h exp=%h/0/%h/%h", cyc,
                 wb_ecode, wb_esubcode, wb_pc, wb_vaddr, e_ecode, e_wb_pc, e_wb_vaddr);
      end
      vectors++;
      if (redirect_pc !== m_rpc || ex_count !== 16'(m_cnt)) begin
        miscompares++;
        $display("FAIL rand_state cyc=%0d rpc=%h cnt=%h exp rpc=%h cnt=%h", cyc, redirect_pc, ex_count, m_rpc, 16'(m_cnt));
      end
      clk_step();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_redir = 0; m_rpc = 32'h0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_commit();
    test_sys_redirect();
    test_priority();
    test_ertn();
    test_saturate_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_commit_ctrl.md
EX_COMMIT_CTRL -- requirements
Module: ex_commit_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL provide these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ws_valid  in  1  instruction present in WB stage
- ws_pc  in  32  PC of WB instruction
- ws_ex  in  5  exception flags {ale, brk, sys, ine, adef}, bit0=adef
- ws_vaddr  in  32  memory address of WB instruction (used for ALE/ADEM)
- ws_ertn  in  1  WB instruction is ERTN
- has_int  in  1  pending enabled interrupt from CSR file
- ex_entry  in  32  exception entry address from CSR file
- ertn_pc  in  32  ERA value from CSR file
- redirect_ready  in  1  fetch stage accepts redirect
- ws_ready  out  1  WB may retire/advance this cycle
- ws_commit  out  1  WB instruction retires normally (writes GPR/CSR)
- wb_ex  out  1  one-cycle exception pulse to CSR file
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  32  faulting PC to CSR file
- wb_vaddr  out  32  bad address to CSR file
- ertn_flush  out  1  one-cycle ERTN pulse to CSR file
- flush_pipe  out  1  kill all younger stages
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- ex_count  out  16  saturating count of taken exceptions and interrupts

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and REDIR.
REQ-004 ws_ready SHALL be 1 in IDLE and 0 in REDIR.
REQ-005 An event SHALL be defined as: state==IDLE and ws_valid and (has_int or ws_ex!=0 or ws_ertn).
REQ-006 The event cause SHALL be selected by fixed priority, highest first:
- INT: ecode 0x00, esub 0
- ADEF: ecode 0x08, esub 0
- INE: ecode 0x0D
- SYS: ecode 0x0B
- BRK: ecode 0x0C
- ALE: ecode 0x09
- ERTN
Esub SHALL be 0 for every cause other than ADEF.
REQ-007 In an event cycle whose cause is not ERTN, the block SHALL assert, combinationally and in that same cycle:
- wb_ex=1
- wb_pc=ws_pc
- wb_vaddr=ws_vaddr
- wb_ecode/wb_esubcode per REQ-006
REQ-008 In an event cycle whose cause is ERTN, the block SHALL assert ertn_flush=1 and wb_ex=0.
REQ-009 wb_ex and ertn_flush SHALL each be high for exactly one cycle per event and SHALL never be high together.
REQ-010 ws_commit SHALL equal state==IDLE and ws_valid and not event; an instruction that takes an exception or interrupt SHALL NOT commit, and an ERTN SHALL NOT commit as a normal instruction.
REQ-011 In an event cycle, the block SHALL assert flush_pipe, register redirect_pc (ex_entry for an exception or interrupt, ertn_pc for ERTN), and transition to REDIR on the next edge.
REQ-012 In REDIR, the block SHALL hold redirect_valid=1, flush_pipe=1 and redirect_pc stable. On redirect_ready=1 the handshake completes and the FSM SHALL return to IDLE on the next edge; redirect_valid SHALL drop in that IDLE cycle.
REQ-013 redirect_valid SHALL be 0 in IDLE. In REDIR, ws_valid and has_int SHALL be ignored: no wb_ex, no commit.
REQ-014 When wb_ex=1, ex_count SHALL increment by 1 and saturate at 0xFFFF; ERTN events SHALL NOT count.
REQ-015 When wb_ex=0 and ertn_flush=0, wb_ecode, wb_esubcode, wb_pc and wb_vaddr SHALL be 0.

Reset
REQ-016 On reset the block SHALL set state=IDLE, redirect_pc=0 and ex_count=0.
REQ-017 Reset asserted while in REDIR SHALL return the FSM to IDLE on the next edge with redirect_valid=0; no pending redirect SHALL survive reset.
REQ-018 While reset is high, wb_ex, ertn_flush, ws_commit, flush_pipe and redirect_valid SHALL all be 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ws_valid=1, ws_ex=0, ws_ertn=0, has_int=0 -> ws_commit=1, wb_ex=0, flush_pipe=0, FSM stays IDLE.
- ws_valid=1, ws_ex=5'b00100 (sys), ws_pc=0x1C000100, ex_entry=0x1C008000 -> wb_ex=1 for 1 cycle, wb_ecode=0x0B, wb_pc=0x1C000100. Next cycle redirect_valid=1 with redirect_pc=0x1C008000 held for 3 cycles while redirect_ready=0; redirect_ready=1 -> IDLE; ex_count=1.
- ws_valid=1, has_int=1, ws_ex=5'b10001 -> ecode=0x00 (INT beats ADEF and ALE), ws_commit=0.
- ws_valid=1, ws_ex=5'b10000 (ale), ws_vaddr=0x00000003 -> ecode=0x09, esub=0, wb_vaddr=0x3. Separately ws_ex=5'b00001 -> ecode=0x08, esub=0.
- ws_valid=1, ws_ertn=1, ertn_pc=0x1C000204 -> ertn_flush=1, wb_ex=0, redirect_pc=0x1C000204, ex_count unchanged. Repeat with ws_ertn=1 and ws_ex=5'b00010 -> INE taken, ertn_flush=0.
- Preload ex_count=0xFFFF and take an exception -> ex_count stays 0xFFFF. Assert reset in REDIR -> redirect_valid=0 next cycle and ex_count=0.
